// File: rtl/druaga_dl_pkg.sv
// druaga_dl_pkg: shared state type and download index
// constants for the Druaga download/reset sequencer.
package druaga_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } dl_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_TNO = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    localparam int NREG = 8;

endpackage

// File: rtl/dl_csum_acc.sv
// dl_csum_acc: one 8-bit modulo-256 byte sum per ROM region,
// cleared at the start of each load.
module dl_csum_acc
    import druaga_dl_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NREG-1:0]      add_en,
    input  logic [7:0]           data,
    output logic [8*NREG-1:0]    sum
);

    logic [7:0] acc [NREG];

    // Clear applies before the add so a byte arriving in the
    // first cycle of a load is still counted.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NREG; n++) begin
                acc[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NREG; n++) begin
                acc[n] <= (clr ? 8'd0 : acc[n])
                        + (add_en[n] ? data : 8'd0);
            end
        end
    end

    for (genvar n = 0; n < NREG; n++) begin : g_out
        assign sum[8*n +: 8] = acc[n];
    end

endmodule

// File: rtl/druaga_dl_sequencer.sv
// druaga_dl_sequencer: routes HPS download bytes to ROM regions,
// latches title/DIP bytes and owns the core reset. Macro: DL_CHECKSUM_EN.
module druaga_dl_sequencer
    import druaga_dl_pkg::*;
#(
    parameter int AW   = 17,
    parameter int HOLD = 16
) (
    input  logic            clk_sys,
    input  logic            RESET,
    input  logic            rst_req,
    input  logic            ioctl_download,
    input  logic            ioctl_wr,
    input  logic [7:0]      ioctl_index,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_dout,
    output logic [NREG-1:0] rom_we,
    output logic [AW-1:0]   rom_addr,
    output logic [7:0]      rom_data,
    output logic [3:0]      tno,
    output logic [23:0]     dsw,
    output logic            core_reset,
    output logic            loaded,
    output logic            ovf,
    output logic [63:0]     csum
);

    localparam logic [7:0] HOLD_N  = 8'(HOLD);
    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    dl_state_t       state, state_nx;
    logic [7:0]      cnt;
    logic            dl_rom;
    logic            wr;
    logic            rom_hit;
    logic            rom_acc;
    logic            enter_load;
    logic            load_done;
    logic            got_rom;
    logic            dip_hit;
    logic [2:0]      region;
    logic [NREG-1:0] we_vec;

    assign dl_rom  = ioctl_download
                   && (ioctl_index == IDX_ROM
                   ||  ioctl_index == IDX_TNO);
    assign wr      = ioctl_download && ioctl_wr;
    assign rom_hit = wr && ioctl_index == IDX_ROM;
    assign rom_acc = rom_hit && ioctl_addr[24:AW+3] == '0;
    assign region  = ioctl_addr[AW+2:AW];
    assign we_vec  = rom_acc ? (NREG'(1) << region) : '0;
    assign dip_hit = wr && ioctl_index == IDX_DIP
                   && ioctl_addr[24:3] == '0
                   && ioctl_addr[2:0] < 3'd3;

    assign enter_load = dl_rom && state != ST_LOAD;
    assign load_done  = state == ST_LOAD && !dl_rom;

    // State register.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state: a ROM/title download preempts everything.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: state_nx = ST_IDLE;
            ST_LOAD: if (!dl_rom) state_nx = ST_HOLD;
            ST_HOLD: begin
                if (cnt == '0) begin
                    if (!loaded)       state_nx = ST_IDLE;
                    else if (!rst_req) state_nx = ST_RUN;
                end
            end
            ST_RUN:  if (rst_req) state_nx = ST_HOLD;
        endcase
        if (dl_rom) state_nx = ST_LOAD;
    end

    // Outputs: the core runs only in RUN.
    always_comb begin
        core_reset = 1'b1;
        unique case (state)
            ST_RUN:  core_reset = 1'b0;
            default: core_reset = 1'b1;
        endcase
    end

    // Hold counter. While rst_req is high it sits at HOLD so the
    // first low cycle leaves HOLD-1, matching the end of a download.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (load_done) begin
            cnt <= HOLD_M1;
        end else if (state_nx == ST_HOLD
                  && (state == ST_RUN || rst_req)) begin
            cnt <= HOLD_N;
        end else if (state == ST_HOLD && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    // Track whether this load accepted any ROM byte; a completed
    // load with data marks the core as loaded for good.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            got_rom <= 1'b0;
            loaded  <= 1'b0;
        end else begin
            if (enter_load)   got_rom <= rom_acc;
            else if (rom_acc) got_rom <= 1'b1;
            if (load_done && got_rom) loaded <= 1'b1;
        end
    end

    // Registered ROM port plus title, DIP and overflow latches.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            rom_we   <= '0;
            rom_addr <= '0;
            rom_data <= '0;
            tno      <= '0;
            dsw      <= '0;
            ovf      <= 1'b0;
        end else begin
            rom_we <= we_vec;
            if (rom_acc) begin
                rom_addr <= ioctl_addr[AW-1:0];
                rom_data <= ioctl_dout;
            end
            if (wr && ioctl_index == IDX_TNO)
                tno <= ioctl_dout[3:0];
            if (dip_hit)
                dsw[{ioctl_addr[1:0], 3'b000} +: 8] <= ioctl_dout;
            if (rom_hit && !rom_acc)
                ovf <= 1'b1;
        end
    end

`ifdef DL_CHECKSUM_EN
    dl_csum_acc u_csum (
        .clk_sys (clk_sys),
        .rst     (RESET),
        .clr     (enter_load),
        .add_en  (we_vec),
        .data    (ioctl_dout),
        .sum     (csum)
    );
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_druaga_dl_sequencer.sv
// tb_druaga_dl_sequencer: directed stimulus, per-cycle model compare
// and literal expectations for druaga_dl_sequencer.
module tb_druaga_dl_sequencer;

    localparam int AW   = 17;
    localparam int HOLD = 16;

    logic          clk_sys        = 1'b0;
    logic          RESET          = 1'b0;
    logic          rst_req        = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr       = 1'b0;
    logic [7:0]    ioctl_index    = '0;
    logic [24:0]   ioctl_addr     = '0;
    logic [7:0]    ioctl_dout     = '0;
    logic [7:0]    rom_we;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [3:0]    tno;
    logic [23:0]   dsw;
    logic          core_reset;
    logic          loaded;
    logic          ovf;
    logic [63:0]   csum;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk_sys = ~clk_sys;

    druaga_dl_sequencer #(.AW(AW), .HOLD(HOLD)) dut (
        .clk_sys        (clk_sys),
        .RESET          (RESET),
        .rst_req        (rst_req),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .tno            (tno),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .loaded         (loaded),
        .ovf            (ovf),
        .csum           (csum)
    );

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Inputs classified by the download rules.
    logic       t_trig, t_wr, t_rom_ok, t_rom_bad;
    logic [2:0] t_reg;
    assign t_trig = ioctl_download
                  && (ioctl_index == 8'd0 || ioctl_index == 8'd1);
    assign t_wr      = ioctl_download && ioctl_wr;
    assign t_rom_ok  = t_wr && ioctl_index == 8'd0
                     && (ioctl_addr >> (AW + 3)) == 0;
    assign t_rom_bad = t_wr && ioctl_index == 8'd0
                     && (ioctl_addr >> (AW + 3)) != 0;
    assign t_reg     = 3'((ioctl_addr >> AW) & 25'd7);

    // m_since: edges since a trigger (download 0/1 or rst_req) was
    // last seen. The core runs once loaded and quiet for HOLD+1 edges.
    logic          m_trig_q, m_got, m_loaded;
    int            m_since;
    logic [7:0]    e_we, e_data;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_tno;
    logic [23:0]   e_dsw;
    logic          e_ovf;
    logic          e_cr;
    logic [63:0]   e_cs;
`ifdef DL_CHECKSUM_EN
    logic [7:0]    m_sum [8];
`endif

    always @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            m_trig_q <= 1'b0;
            m_got    <= 1'b0;
            m_loaded <= 1'b0;
            m_since  <= 0;
            e_we     <= '0;
            e_addr   <= '0;
            e_data   <= '0;
            e_tno    <= '0;
            e_dsw    <= '0;
            e_ovf    <= 1'b0;
`ifdef DL_CHECKSUM_EN
            for (int r = 0; r < 8; r++) m_sum[r] <= '0;
`endif
        end else begin
            m_trig_q <= t_trig;
            m_since  <= (t_trig || rst_req) ? 0 : m_since + 1;
            if (t_trig && !m_trig_q) m_got <= t_rom_ok;
            else if (t_rom_ok)       m_got <= 1'b1;
            if (!t_trig && m_trig_q && m_got) m_loaded <= 1'b1;
            e_we <= t_rom_ok ? 8'(1 << t_reg) : 8'h00;
            if (t_rom_ok) begin
                e_addr <= ioctl_addr[AW-1:0];
                e_data <= ioctl_dout;
            end
            if (t_wr && ioctl_index == 8'd1) e_tno <= ioctl_dout[3:0];
            if (t_wr && ioctl_index == 8'd254) begin
                case (ioctl_addr)
                    25'd0:   e_dsw[7:0]   <= ioctl_dout;
                    25'd1:   e_dsw[15:8]  <= ioctl_dout;
                    25'd2:   e_dsw[23:16] <= ioctl_dout;
                    default: ;
                endcase
            end
            if (t_rom_bad) e_ovf <= 1'b1;
`ifdef DL_CHECKSUM_EN
            for (int r = 0; r < 8; r++) begin
                if (t_trig && !m_trig_q)
                    m_sum[r] <= (t_rom_ok && t_reg == r) ? ioctl_dout : 8'd0;
                else if (t_rom_ok && t_reg == r)
                    m_sum[r] <= m_sum[r] + ioctl_dout;
            end
`endif
        end
    end

    always_comb begin
        e_cr = !(m_loaded && m_since >= HOLD + 1);
        e_cs = '0;
`ifdef DL_CHECKSUM_EN
        for (int r = 0; r < 8; r++) e_cs[8*r +: 8] = m_sum[r];
`endif
    end

    // Per-cycle compare on the falling edge.
    always @(negedge clk_sys) begin
        if (cmp_on) begin
            chk("m_rom_we", rom_we, e_we);
            if (e_we != 0) begin
                chk("m_rom_addr", rom_addr, e_addr);
                chk("m_rom_data", rom_data, e_data);
            end
            chk("m_tno", tno, e_tno);
            chk("m_dsw", dsw, e_dsw);
            chk("m_core_reset", core_reset, e_cr);
            chk("m_loaded", loaded, m_loaded);
            chk("m_ovf", ovf, e_ovf);
            chk("m_csum", csum, e_cs);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] idx,
                           input logic [24:0] a,
                           input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    // Count edges until core_reset is low; lim+1 means it never fell.
    task automatic wait_fall(input int lim, output int n);
        n = lim + 1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (core_reset === 1'b0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_we"}, rom_we, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_rom_data"}, rom_data, 0);
        chk({tag, "_tno"}, tno, 0);
        chk({tag, "_dsw"}, dsw, 0);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_csum"}, csum, 0);
    endtask

    initial begin
        int n;
        #2 RESET = 1'b1;
        cmp_on = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 RESET = 1'b0;
        chk_reset_vals("rst");

        // ROM download with two test-plan bytes then a burst
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        chk("dl_core_reset", core_reset, 1);
        wr_byte(8'd0, 25'h00000, 8'hA5);
        chk("we0", rom_we, 8'h01);
        chk("addr0", rom_addr, 0);
        chk("data0", rom_data, 8'hA5);
        wr_byte(8'd0, 25'h20001, 8'h3C);
        chk("we1", rom_we, 8'h02);
        chk("addr1", rom_addr, 1);
        chk("data1", rom_data, 8'h3C);
`ifdef DL_CHECKSUM_EN
        chk("csum01", csum[15:0], 16'h3CA5);
`else
        chk("csum_off", csum, 0);
`endif
        for (int i = 0; i < 4; i++)
            wr_byte(8'd0, 25'(25'hE0000 + i), 8'(8'h10 + i));
        chk("we7", rom_we, 8'h80);
        tick();
        chk("we_one_cycle", rom_we, 0);
        ioctl_download = 1'b0;
        wait_fall(40, n);
        chk("dl_hold_cycles", n, 17);
        chk("loaded_set", loaded, 1);

        // DIP bytes while running
        ioctl_index    = 8'd254;
        ioctl_download = 1'b1;
        tick();
        chk("dip_run0", core_reset, 0);
        wr_byte(8'd254, 25'd0, 8'h11);
        wr_byte(8'd254, 25'd1, 8'h22);
        wr_byte(8'd254, 25'd2, 8'h33);
        wr_byte(8'd254, 25'd3, 8'h44);
        wr_byte(8'd254, 25'd8, 8'h55);
        ioctl_download = 1'b0;
        tick();
        chk("dsw", dsw, 24'h332211);
        chk("dip_run1", core_reset, 0);

        // Title byte download: LOAD, HOLD, back to RUN
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        chk("tno_core_reset", core_reset, 1);
        wr_byte(8'd1, 25'd0, 8'hF3);
        chk("tno", tno, 4'h3);
        ioctl_download = 1'b0;
        wait_fall(40, n);
        chk("tno_hold_cycles", n, 17);

        // Overflowing ROM address, then re-entry during HOLD
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        wr_byte(8'd0, 25'h100000, 8'h77);
        chk("ovf_no_we", rom_we, 0);
        chk("ovf_set", ovf, 1);
        ioctl_download = 1'b0;
        repeat (5) tick();
        ioctl_download = 1'b1;
        tick();
        chk("hold_reenter", core_reset, 1);
        ioctl_download = 1'b0;
        wait_fall(40, n);
        chk("reenter_hold_cycles", n, 17);
        chk("ovf_sticky", ovf, 1);

        // rst_req held 5 cycles in RUN
        rst_req = 1'b1;
        n = 61;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 5) rst_req = 1'b0;
            if (core_reset === 1'b0) begin
                n = k;
                break;
            end
        end
        chk("rst_req_cycles", n, 22);

        // rst_req high across a load end
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        rst_req        = 1'b1;
        tick();
        wr_byte(8'd0, 25'h40002, 8'h5A);
        repeat (3) tick();
        ioctl_download = 1'b0;
        repeat (10) tick();
        chk("rst_hold_wait", core_reset, 1);
        rst_req = 1'b0;
        wait_fall(40, n);
        chk("rst_load_cycles", n, 17);

        // RESET mid-load clears everything immediately
        ioctl_download = 1'b1;
        tick();
        wr_byte(8'd0, 25'h60003, 8'hC4);
        chk("pre_reset_we", rom_we, 8'h08);
        RESET = 1'b1;
        #1;
        chk_reset_vals("async");
        ioctl_download = 1'b0;
        tick();
        tick();
        RESET = 1'b0;

        // Title-only load with nothing loaded: core stays in reset
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        tick();
        wr_byte(8'd1, 25'd0, 8'h09);
        ioctl_download = 1'b0;
        repeat (30) tick();
        chk("no_rom_idle", core_reset, 1);
        chk("no_rom_tno", tno, 4'h9);
        chk("no_rom_loaded", loaded, 0);
        tick();

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
